// File: rtl/xpb_lut_bank.sv
// Runtime-loaded bank of NUM_TABLES constant tables with one parallel lookup and a full-precision sum.
// Lookup latency is 2 cycles at 1/cycle; in_ready falls when both stages are full and out_ready is low, and held outputs stay stable.
module xpb_lut_bank #(
  parameter int WIDTH      = 1024,
  parameter int IDX_BITS   = 5,
  parameter int NUM_TABLES = 4,
  parameter int LOAD_W     = 64,
  localparam int SUM_W     = (NUM_TABLES > 1) ? WIDTH + $clog2(NUM_TABLES) : WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_start,
  input  logic                           cfg_valid,
  input  logic [LOAD_W-1:0]              cfg_data,
  output logic                           cfg_done,
  output logic                           loaded,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_TABLES*IDX_BITS-1:0] in_idx,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_TABLES*WIDTH-1:0]    out_data,
  output logic [SUM_W-1:0]               out_sum
);

  localparam int WPE   = (WIDTH + LOAD_W - 1) / LOAD_W;
  localparam int DEPTH = 1 << IDX_BITS;
  localparam int WB    = (WPE > 1) ? $clog2(WPE) : 1;
  localparam int TBL_B = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  state_t                        r_state;
  logic                          r_loaded;
  logic                          r_cfg_done;
  logic [WB-1:0]                 r_ptr_word;
  logic [IDX_BITS-1:0]           r_ptr_idx;
  logic [TBL_B-1:0]              r_ptr_tbl;

  logic [WIDTH-1:0]              r_mem [NUM_TABLES][DEPTH];

  logic                          r_s1_vld;
  logic [NUM_TABLES*WIDTH-1:0]   r_s1_dat;
  logic                          r_out_vld;
  logic [NUM_TABLES*WIDTH-1:0]   r_out_dat;
  logic [SUM_W-1:0]              r_out_sum;

  logic                          w_wr_en;
  logic                          w_last;
  logic                          w_word_last;
  logic [WIDTH-1:0]              w_wmask;
  logic [WIDTH-1:0]              w_wdat;
  logic [WIDTH-1:0]              w_cur;
  logic [WIDTH-1:0]              w_wr_entry;
  logic [NUM_TABLES*WIDTH-1:0]   w_rd_dat;
  logic [SUM_W-1:0]              w_sum;
  logic                          w_s2_adv;
  logic                          w_s1_adv;
  logic                          w_acc;

  // cfg_start wins over a same-cycle load word, so that word never reaches storage.
  assign w_wr_en     = (r_state == ST_LOADING) && cfg_valid && !cfg_start;
  assign w_word_last = (r_ptr_word == WB'(WPE - 1));
  assign w_last      = w_word_last && (r_ptr_idx == '1) && (r_ptr_tbl == TBL_B'(NUM_TABLES - 1));

  always_comb begin
    w_wmask = '0;
    w_wdat  = '0;
    for (int b = 0; b < WIDTH; b++) begin
      w_wmask[b] = ((b / LOAD_W) == int'(r_ptr_word));
      w_wdat[b]  = cfg_data[b % LOAD_W];
    end
  end

  assign w_cur      = r_mem[r_ptr_tbl][r_ptr_idx];
  assign w_wr_entry = (w_cur & ~w_wmask) | (w_wdat & w_wmask);

  // Storage deliberately survives reset and cfg_start; only the pointer restarts.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_ptr_tbl][r_ptr_idx] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_loaded   <= 1'b0;
      r_cfg_done <= 1'b0;
      r_ptr_word <= '0;
      r_ptr_idx  <= '0;
      r_ptr_tbl  <= '0;
    end else begin
      r_cfg_done <= 1'b0;
      if (cfg_start) begin
        r_state    <= ST_LOADING;
        r_loaded   <= 1'b0;
        r_ptr_word <= '0;
        r_ptr_idx  <= '0;
        r_ptr_tbl  <= '0;
      end else if (w_wr_en) begin
        if (w_last) begin
          r_state    <= ST_READY;
          r_loaded   <= 1'b1;
          r_cfg_done <= 1'b1;
          r_ptr_word <= '0;
          r_ptr_idx  <= '0;
          r_ptr_tbl  <= '0;
        end else if (w_word_last) begin
          r_ptr_word <= '0;
          if (r_ptr_idx == '1) begin
            r_ptr_idx <= '0;
            r_ptr_tbl <= r_ptr_tbl + TBL_B'(1);
          end else begin
            r_ptr_idx <= r_ptr_idx + IDX_BITS'(1);
          end
        end else begin
          r_ptr_word <= r_ptr_word + WB'(1);
        end
      end
    end
  end

  always_comb begin
    w_rd_dat = '0;
    for (int t = 0; t < NUM_TABLES; t++) begin
      w_rd_dat[t*WIDTH +: WIDTH] = r_mem[t][in_idx[t*IDX_BITS +: IDX_BITS]];
    end
  end

  always_comb begin
    w_sum = '0;
    for (int t = 0; t < NUM_TABLES; t++) begin
      w_sum = w_sum + SUM_W'(r_s1_dat[t*WIDTH +: WIDTH]);
    end
  end

  assign w_s2_adv = !r_out_vld || out_ready;
  assign w_s1_adv = !r_s1_vld || w_s2_adv;
  assign w_acc    = in_valid && r_loaded && w_s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_dat  <= '0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_out_sum <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_vld <= w_acc;
        if (w_acc) begin
          r_s1_dat <= w_rd_dat;
        end
      end
      if (w_s2_adv) begin
        r_out_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_out_dat <= r_s1_dat;
          r_out_sum <= w_sum;
        end
      end
    end
  end

  assign cfg_done  = r_cfg_done;
  assign loaded    = r_loaded;
  assign in_ready  = r_loaded && w_s1_adv;
  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;
  assign out_sum   = r_out_sum;

endmodule
